oled_frame_sequencer: RTL and testbench
=======================================

# oled_frame_sequencer

Upstream command/data feeder for the I2C master driving the 128x64 SSD1306 OLED. On `start` it walks a 31-byte init command ROM and then streams the 1024-byte framebuffer; on `refresh` it resends only the addressing window and framebuffer. It presents each control, command and data byte to the master and advances on the master's per-byte queue pointers. It also flags normal completion or a NACK abort.

## Interface
- `SLAVE_ADDR`, 7'h3C: OLED I2C address driven on `m_slave_addr`.
- `FB_BYTES`, 1024: framebuffer length in bytes.
- `CLK` in 1: system clock. The only clock.
- `RST` in 1: reset. Synchronous, active-high.
- `start` in 1: one-cycle pulse; full init plus frame.
- `refresh` in 1: one-cycle pulse; window commands plus frame.
- `busy` out 1: high from accepted request until return to S_IDLE.
- `done` out 1: one-cycle pulse on normal completion.
- `error` out 1: sticky NACK/abort flag; cleared by the next accepted request or `RST`.
- `m_enable_n` out 1: active-low transaction request to the master.
- `m_slave_addr` out 7: constant `SLAVE_ADDR`.
- `m_read_write` out 1: constant 0.
- `m_control_frame` out 8: 0x80 for a command byte, 0xC0 for a data byte.
- `m_reg_addr` out 8: current command byte.
- `m_data_write` out 8: current data byte.
- `m_stop_req` out 1: asks the master to issue STOP after the current byte's ACK.
- `m_state` in 4: master state code.
- `m_cmd_ptr` in 1: toggles per command byte sent.
- `m_data_ptr` in 8: increments per data byte sent.
- `fb_addr` out 10: framebuffer read address.
- `fb_data` in 8: framebuffer read data, 1-cycle latency.

## Operation
- States:
  - S_IDLE: `busy`=0.
  - S_REQ: `m_enable_n`=0 until `m_state`≠IDLE, then go to S_CMD.
  - S_CMD: command bytes.
  - S_DATA: data bytes.
  - S_FINISH: wait for master IDLE.
- Requests:
  - `start` loads ROM index 0 and ends commands at index 30.
  - `refresh` loads index 24 and ends at index 29.
  - `start` and `refresh` in the same cycle: `start` wins.
  - Either request while `busy`=1 is ignored.
  - `refresh` before any completed `start` is ignored; the init_done flag is cleared by `RST`.
- Init ROM, idx 0..30: AE, D5 80, A8 3F, D3 00, 40, 8D 14, 20 00, A0, C0, DA 12, 81 CF, D9 F1, DB 40, A4, A6, 21 00 7F, 22 00 07, AF.
- Advance detection: registered copies of `m_cmd_ptr` and `m_data_ptr`. A mismatch means the current byte was sent; present the next byte on the following cycle.
- S_CMD:
  - `m_reg_addr` = ROM[idx].
  - `m_control_frame` = 0x80.
  - On the last command's advance, go to S_DATA with data index 0.
- S_DATA:
  - `m_control_frame` = 0xC0.
  - `fb_addr` = data index.
  - `m_data_write` is registered from `fb_data` every cycle.
- `fb_addr` is driven to 0 from entry to S_REQ, so byte 0 is valid before the first data phase.
- `m_stop_req` is set when data index `FB_BYTES`-1 is presented, then go to S_FINISH.
- S_FINISH:
  - `m_state` == IDLE (0): pulse `done`, set init_done, clear `m_stop_req`, go to S_IDLE.
- Abort: `m_state` reaching STOP (8) or IDLE in S_CMD or S_DATA means a NACK. Set `error` and go to S_IDLE without `done`.
- Data index is 10 bits and never wraps inside one frame.

## Timing
- Reset values:
  - `m_enable_n`=1.
  - `busy`=0, `done`=0, `error`=0, `m_stop_req`=0.
  - `m_control_frame`=0x80, `m_reg_addr`=0xAE, `m_data_write`=0x00.
  - `fb_addr`=0.
  - FSM in S_IDLE; init_done=0.
- `RST` mid-frame returns to these values immediately. The next transfer needs a fresh `start`.
- Request to `m_enable_n` low: 1 cycle.
- Pointer change to next byte valid: 2 cycles (1 detect, 1 register). This is far inside the master's ACK window.
- `fb_data` to `m_data_write`: 1 cycle.
- Simultaneous cmd and data pointer change is illegal. Assert in simulation; the command advance takes priority.

## Configuration
- `OLED_ROTATE180_EN`:
  - Defined: ROM idx 12 = A1 (segment remap) and idx 13 = C8 (COM scan reversed).
  - Undefined: A0 and C0.
  - No other behaviour changes.

## Structure
- Shared package `oled_pkg`:
  - Master state codes (IDLE=0, STOP=8).
  - Control byte constants CTRL_CMD=0x80 and CTRL_DATA=0xC0.
  - ROM length 31; window start 24 and end 29.
  - Sequencer state enum.
- One sub-module: `oled_init_rom`. Combinational 5-bit index to 8-bit command, holding the `OLED_ROTATE180_EN` selection.

## Test plan
- `start`, master model ACKs all bytes → 31 commands in ROM order each with control 0x80, then 1024 data bytes = `fb_data` for addr 0..1023 with 0xC0. `m_stop_req` rises at byte 1023; `done` pulses once.
- `refresh` after done → exactly 21 00 7F 22 00 07 then 1024 data bytes; `done`.
- `refresh` after `RST` with no prior `start` → ignored, `busy` stays 0.
- Master NACKs the 5th command (returns STOP) → `error`=1, no `done`, FSM in S_IDLE. Next `start` clears `error`.
- `RST` during data byte 500 → all outputs at reset values next cycle. `start` restarts from ROM idx 0.
- `OLED_ROTATE180_EN` defined → command positions 12 and 13 are A1 and C8; undefined → A0 and C0.

Source files
------------

// File: rtl/oled_pkg.sv
// Shared definitions for the SSD1306 OLED frame sequencer: master state
// codes, control bytes, init ROM window bounds and the sequencer state enum.
package oled_pkg;

    // I2C master state codes observed on m_state
    localparam logic [3:0] MST_IDLE = 4'd0;
    localparam logic [3:0] MST_STOP = 4'd8;

    // SSD1306 control bytes preceding each payload byte
    localparam logic [7:0] CTRL_CMD  = 8'h80;
    localparam logic [7:0] CTRL_DATA = 8'hC0;

    // Init ROM geometry; the refresh window resends only column/page addressing
    localparam int         ROM_LEN   = 31;
    localparam logic [4:0] ROM_FIRST = 5'd0;
    localparam logic [4:0] ROM_LAST  = 5'(ROM_LEN - 1);
    localparam logic [4:0] WIN_START = 5'd24;
    localparam logic [4:0] WIN_END   = 5'd29;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_REQ    = 3'd1,
        S_CMD    = 3'd2,
        S_DATA   = 3'd3,
        S_FINISH = 3'd4
    } seq_state_t;

endpackage

// File: rtl/oled_init_rom.sv
// SSD1306 init command ROM: combinational 5-bit index to 8-bit command.
// Build option OLED_ROTATE180_EN selects segment remap A1 and reversed COM
// scan C8 at indices 12/13 (display rotated 180 degrees); otherwise A0/C0.
module oled_init_rom
    import oled_pkg::*;
(
    input  logic [4:0] idx,
    output logic [7:0] cmd
);

`ifdef OLED_ROTATE180_EN
    localparam logic [7:0] SEG_REMAP = 8'hA1;
    localparam logic [7:0] COM_SCAN  = 8'hC8;
`else
    localparam logic [7:0] SEG_REMAP = 8'hA0;
    localparam logic [7:0] COM_SCAN  = 8'hC0;
`endif

    // Command table lookup; indices past the table read as 0x00
    always_comb begin
        cmd = 8'h00;
        case (idx)
            5'd0:  cmd = 8'hAE;   // display off
            5'd1:  cmd = 8'hD5;   // clock divide
            5'd2:  cmd = 8'h80;
            5'd3:  cmd = 8'hA8;   // multiplex ratio
            5'd4:  cmd = 8'h3F;
            5'd5:  cmd = 8'hD3;   // display offset
            5'd6:  cmd = 8'h00;
            5'd7:  cmd = 8'h40;   // start line 0
            5'd8:  cmd = 8'h8D;   // charge pump
            5'd9:  cmd = 8'h14;
            5'd10: cmd = 8'h20;   // horizontal addressing mode
            5'd11: cmd = 8'h00;
            5'd12: cmd = SEG_REMAP;
            5'd13: cmd = COM_SCAN;
            5'd14: cmd = 8'hDA;   // COM pins
            5'd15: cmd = 8'h12;
            5'd16: cmd = 8'h81;   // contrast
            5'd17: cmd = 8'hCF;
            5'd18: cmd = 8'hD9;   // precharge
            5'd19: cmd = 8'hF1;
            5'd20: cmd = 8'hDB;   // VCOMH
            5'd21: cmd = 8'h40;
            5'd22: cmd = 8'hA4;   // resume from RAM
            5'd23: cmd = 8'hA6;   // normal polarity
            5'd24: cmd = 8'h21;   // column window 0..127
            5'd25: cmd = 8'h00;
            5'd26: cmd = 8'h7F;
            5'd27: cmd = 8'h22;   // page window 0..7
            5'd28: cmd = 8'h00;
            5'd29: cmd = 8'h07;
            5'd30: cmd = 8'hAF;   // display on
            default: cmd = 8'h00;
        endcase
    end

endmodule

// File: rtl/oled_frame_sequencer.sv
// Feeds the I2C master with the SSD1306 init sequence and 1024-byte frame.
// start: full init ROM + frame; refresh: addressing window + frame.
// Build option OLED_ROTATE180_EN (in oled_init_rom) flips the panel 180 deg.
//
// Handshake: a byte is presented on m_control_frame plus m_reg_addr or
// m_data_write and held until the master moves its queue pointer
// (m_cmd_ptr toggles / m_data_ptr increments). A pointer differing from its
// registered copy marks the byte as consumed; the next byte is registered
// on the following edge. m_state leaving IDLE acknowledges m_enable_n.
module oled_frame_sequencer
    import oled_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR = 7'h3C,
    parameter int         FB_BYTES   = 1024
)
(
    input  logic       CLK,
    input  logic       RST,
    input  logic       start,
    input  logic       refresh,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic       m_enable_n,
    output logic [6:0] m_slave_addr,
    output logic       m_read_write,
    output logic [7:0] m_control_frame,
    output logic [7:0] m_reg_addr,
    output logic [7:0] m_data_write,
    output logic       m_stop_req,
    input  logic [3:0] m_state,
    input  logic       m_cmd_ptr,
    input  logic [7:0] m_data_ptr,
    output logic [9:0] fb_addr,
    input  logic [7:0] fb_data,
    output logic [2:0] dbg_state
);

    localparam logic [9:0] DATA_LAST = 10'(FB_BYTES - 1);

    seq_state_t state, state_d;
    logic [4:0] idx, idx_d;
    logic [4:0] end_idx, end_idx_d;
    logic [9:0] data_idx, data_idx_d;
    logic       init_done, init_done_d;
    logic       busy_d, done_d, error_d, enable_n_d, stop_d;
    logic [7:0] ctrl_d;
    logic [9:0] fb_addr_d;
    logic       cmd_ptr_q;
    logic [7:0] data_ptr_q;
    logic [7:0] rom_cmd;
    logic       cmd_adv, data_adv, mst_gone;

    // ROM is addressed by the next index so m_reg_addr registers ROM[idx]
    oled_init_rom u_rom (
        .idx (idx_d),
        .cmd (rom_cmd)
    );

    assign cmd_adv      = (m_cmd_ptr != cmd_ptr_q);
    assign data_adv     = (m_data_ptr != data_ptr_q);
    assign mst_gone     = (m_state == MST_STOP) || (m_state == MST_IDLE);
    assign m_slave_addr = SLAVE_ADDR;
    assign m_read_write = 1'b0;
    assign dbg_state    = state;

    // Next-state and next-output logic
    always_comb begin
        state_d     = state;
        idx_d       = idx;
        end_idx_d   = end_idx;
        data_idx_d  = data_idx;
        init_done_d = init_done;
        done_d      = 1'b0;
        error_d     = error;
        enable_n_d  = m_enable_n;
        stop_d      = m_stop_req;
        ctrl_d      = m_control_frame;
        fb_addr_d   = fb_addr;

        case (state)
            S_IDLE: begin
                // start beats refresh; refresh needs a prior completed start
                if (start || (refresh && init_done)) begin
                    state_d    = S_REQ;
                    idx_d      = start ? ROM_FIRST : WIN_START;
                    end_idx_d  = start ? ROM_LAST : WIN_END;
                    error_d    = 1'b0;
                    enable_n_d = 1'b0;
                    stop_d     = 1'b0;
                    ctrl_d     = CTRL_CMD;
                    data_idx_d = 10'd0;
                    fb_addr_d  = 10'd0;   // prefetch byte 0 during commands
                end
            end
            S_REQ: begin
                if (m_state != MST_IDLE) begin
                    state_d    = S_CMD;
                    enable_n_d = 1'b1;
                end
            end
            S_CMD: begin
                if (mst_gone) begin
                    state_d = S_IDLE;
                    error_d = 1'b1;
                    stop_d  = 1'b0;
                end else if (cmd_adv) begin
                    if (idx == end_idx) begin
                        state_d    = S_DATA;
                        ctrl_d     = CTRL_DATA;
                        data_idx_d = 10'd0;
                        fb_addr_d  = 10'd0;
                    end else begin
                        idx_d = idx + 5'd1;
                    end
                end
            end
            S_DATA: begin
                if (mst_gone) begin
                    state_d = S_IDLE;
                    error_d = 1'b1;
                    stop_d  = 1'b0;
                end else if (data_adv && !cmd_adv) begin
                    data_idx_d = data_idx + 10'd1;
                    fb_addr_d  = data_idx + 10'd1;
                    if ((data_idx + 10'd1) == DATA_LAST) begin
                        stop_d  = 1'b1;
                        state_d = S_FINISH;
                    end
                end
            end
            S_FINISH: begin
                if (m_state == MST_IDLE) begin
                    done_d      = 1'b1;
                    init_done_d = 1'b1;
                    stop_d      = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // FSM and control register bank
    always_ff @(posedge CLK) begin
        if (RST) begin
            state           <= S_IDLE;
            idx             <= ROM_FIRST;
            end_idx         <= ROM_LAST;
            data_idx        <= 10'd0;
            init_done       <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            error           <= 1'b0;
            m_enable_n      <= 1'b1;
            m_stop_req      <= 1'b0;
            m_control_frame <= CTRL_CMD;
            fb_addr         <= 10'd0;
        end else begin
            state           <= state_d;
            idx             <= idx_d;
            end_idx         <= end_idx_d;
            data_idx        <= data_idx_d;
            init_done       <= init_done_d;
            busy            <= busy_d;
            done            <= done_d;
            error           <= error_d;
            m_enable_n      <= enable_n_d;
            m_stop_req      <= stop_d;
            m_control_frame <= ctrl_d;
            fb_addr         <= fb_addr_d;
        end
    end

    // Byte registers and pointer copies used for advance detection
    always_ff @(posedge CLK) begin
        if (RST) begin
            m_reg_addr   <= 8'hAE;
            m_data_write <= 8'h00;
            cmd_ptr_q    <= 1'b0;
            data_ptr_q   <= 8'h00;
        end else begin
            m_reg_addr   <= rom_cmd;
            m_data_write <= fb_data;
            cmd_ptr_q    <= m_cmd_ptr;
            data_ptr_q   <= m_data_ptr;
        end
    end

    // The master never moves both queue pointers in the same cycle
    a_single_adv: assert property (@(posedge CLK) disable iff (RST)
        ((state == S_CMD) || (state == S_DATA)) |-> !(cmd_adv && data_adv));

endmodule

// File: tb/tb_oled_frame_sequencer.sv
// Bench for oled_frame_sequencer: byte-level master model, framebuffer
// model and an expected-byte queue filled whenever a request is issued.
module tb_oled_frame_sequencer;
    import oled_pkg::*;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       start = 1'b0;
    logic       refresh = 1'b0;
    logic       busy, done, error, m_enable_n, m_read_write, m_stop_req;
    logic [6:0] m_slave_addr;
    logic [7:0] m_control_frame, m_reg_addr, m_data_write;
    logic [3:0] m_state = 4'd0;
    logic       m_cmd_ptr = 1'b0;
    logic [7:0] m_data_ptr = 8'd0;
    logic [9:0] fb_addr;
    logic [7:0] fb_data = 8'd0;
    logic [2:0] dbg_state;

    logic [7:0]  fb_mem [0:1023];
    logic [7:0]  rom_model [0:30];
    logic [16:0] exp_q[$];   // {control, byte, stop_req}
    int n_pass = 0;
    int n_total = 0;
    int done_cnt = 0;

    typedef struct {
        bit do_reset;
        bit s;
        bit r;
        int nack_cmd;      // 0 = master ACKs everything
        bit poke;          // fire requests while busy
        bit exp_accept;
        bit exp_full;
        bit exp_error;
        int exp_done;
    } vec_t;
    vec_t vecs[6];

    oled_frame_sequencer dut (
        .CLK(CLK), .RST(RST), .start(start), .refresh(refresh),
        .busy(busy), .done(done), .error(error), .m_enable_n(m_enable_n),
        .m_slave_addr(m_slave_addr), .m_read_write(m_read_write),
        .m_control_frame(m_control_frame), .m_reg_addr(m_reg_addr),
        .m_data_write(m_data_write), .m_stop_req(m_stop_req),
        .m_state(m_state), .m_cmd_ptr(m_cmd_ptr), .m_data_ptr(m_data_ptr),
        .fb_addr(fb_addr), .fb_data(fb_data), .dbg_state(dbg_state)
    );

    // Clock and reset-independent models
    always #5 CLK = ~CLK;
    always @(posedge CLK) fb_data <= fb_mem[fb_addr];
    always @(negedge CLK) if (done === 1'b1) done_cnt = done_cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    task automatic check_reset_vals();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_enable_n", m_enable_n, 1);
        check("rst_stop_req", m_stop_req, 0);
        check("rst_ctrl", m_control_frame, 8'h80);
        check("rst_reg_addr", m_reg_addr, 8'hAE);
        check("rst_data_write", m_data_write, 8'h00);
        check("rst_fb_addr", fb_addr, 0);
        check("rst_state", dbg_state, 0);
        check("slave_addr", m_slave_addr, 7'h3C);
        check("read_write", m_read_write, 0);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1; m_state = MST_IDLE; m_cmd_ptr = 1'b0; m_data_ptr = 8'd0;
        repeat (3) @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic pulse_req(input bit s, input bit r);
        @(negedge CLK);
        start = s; refresh = r;
        @(negedge CLK);
        start = 1'b0; refresh = 1'b0;
    endtask

    task automatic push_frame(input bit full);
        int lo = full ? 0 : 24;
        int hi = full ? 30 : 29;
        for (int i = lo; i <= hi; i++) exp_q.push_back({CTRL_CMD, rom_model[i], 1'b0});
        for (int d = 0; d < 1024; d++) exp_q.push_back({CTRL_DATA, fb_mem[d], (d == 1023)});
    endtask

    // Byte-level I2C master model; every presented byte is checked against exp_q
    task automatic run_master(input int nack_cmd, input bit rst_mid, input bit poke);
        int waitc = 0;
        int ncmd = 0;
        int ndata = 0;
        logic [7:0]  ctrl;
        logic [16:0] act, expv;
        while (m_enable_n !== 1'b0 && waitc < 20) begin
            @(negedge CLK);
            waitc++;
        end
        check("enable_low", m_enable_n, 0);
        if (m_enable_n !== 1'b0) return;
        check("busy_on_accept", busy, 1);
        check("error_cleared", error, 0);
        m_state = 4'd1;
        for (int b = 0; b < 1100; b++) begin
            repeat (4) @(negedge CLK);
            ctrl = m_control_frame;
            act = {ctrl, (ctrl == CTRL_DATA) ? m_data_write : m_reg_addr, m_stop_req};
            if (exp_q.size() == 0) begin
                check("queue_underrun", 1, 0);
                m_state = MST_STOP;
                @(negedge CLK);
                m_state = MST_IDLE;
                return;
            end
            expv = exp_q.pop_front();
            if (ctrl == CTRL_DATA) begin
                check("data_byte", act, expv);
                ndata++;
            end else begin
                check("cmd_byte", act, expv);
                ncmd++;
            end
            if (poke && ctrl == CTRL_CMD && ncmd == 10) pulse_req(1, 1);
            if (ctrl == CTRL_CMD && ncmd == nack_cmd) begin
                m_state = MST_STOP;
                repeat (2) @(negedge CLK);
                m_state = MST_IDLE;
                repeat (2) @(negedge CLK);
                return;
            end
            if (rst_mid && ctrl == CTRL_DATA && ndata == 501) begin
                RST = 1'b1; m_state = MST_IDLE; m_cmd_ptr = 1'b0; m_data_ptr = 8'd0;
                @(negedge CLK);
                check_reset_vals();
                RST = 1'b0;
                return;
            end
            if (ctrl == CTRL_DATA && act[0]) begin
                m_data_ptr = m_data_ptr + 8'd1;
                @(negedge CLK);
                m_state = MST_STOP;
                @(negedge CLK);
                m_state = MST_IDLE;
                repeat (3) @(negedge CLK);
                return;
            end
            if (ctrl == CTRL_CMD) m_cmd_ptr = ~m_cmd_ptr;
            else m_data_ptr = m_data_ptr + 8'd1;
        end
        check("master_byte_budget", 1, 0);
        m_state = MST_IDLE;
    endtask

    initial begin
        int done_before;
        bit en_seen;

        rom_model = '{8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40,
                      8'h8D, 8'h14, 8'h20, 8'h00, 8'hA0, 8'hC0, 8'hDA, 8'h12,
                      8'h81, 8'hCF, 8'hD9, 8'hF1, 8'hDB, 8'h40, 8'hA4, 8'hA6,
                      8'h21, 8'h00, 8'h7F, 8'h22, 8'h00, 8'h07, 8'hAF};
`ifdef OLED_ROTATE180_EN
        rom_model[12] = 8'hA1;
        rom_model[13] = 8'hC8;
`endif
        for (int i = 0; i < 1024; i++) fb_mem[i] = 8'($urandom_range(0, 255));

        //             rst s  r  nack poke acc full err done
        vecs[0] = '{1, 0, 1, 0, 0, 0, 0, 0, 0};   // refresh before any start
        vecs[1] = '{0, 1, 0, 0, 1, 1, 1, 0, 1};   // full frame, pokes while busy
        vecs[2] = '{0, 0, 1, 0, 0, 1, 0, 0, 1};   // refresh after done
        vecs[3] = '{0, 1, 1, 0, 0, 1, 1, 0, 1};   // simultaneous: start wins
        vecs[4] = '{0, 1, 0, 5, 0, 1, 1, 1, 0};   // NACK on 5th command
        vecs[5] = '{0, 0, 1, 0, 0, 1, 0, 0, 1};   // next request clears error

        repeat (3) @(negedge CLK);
        check_reset_vals();
        RST = 1'b0;

        for (int v = 0; v < 6; v++) begin
            if (vecs[v].do_reset) do_reset();
            done_before = done_cnt;
            if (vecs[v].exp_accept) push_frame(vecs[v].exp_full);
            pulse_req(vecs[v].s, vecs[v].r);
            if (vecs[v].exp_accept) begin
                run_master(vecs[v].nack_cmd, 0, vecs[v].poke);
            end else begin
                en_seen = 0;
                repeat (10) begin
                    @(negedge CLK);
                    if (m_enable_n !== 1'b1 || busy !== 1'b0) en_seen = 1;
                end
                check("request_ignored", en_seen, 0);
            end
            repeat (4) @(negedge CLK);
            check("busy_end", busy, 0);
            check("error_end", error, vecs[v].exp_error);
            check("done_count", done_cnt - done_before, vecs[v].exp_done);
            check("state_end", dbg_state, 0);
            if (vecs[v].nack_cmd != 0) exp_q.delete();
            else check("queue_drained", exp_q.size(), 0);
        end

        // Reset in the middle of data byte 500, then refresh must be ignored
        push_frame(1);
        pulse_req(1, 0);
        run_master(0, 1, 0);
        exp_q.delete();
        pulse_req(0, 1);
        en_seen = 0;
        repeat (10) begin
            @(negedge CLK);
            if (m_enable_n !== 1'b1 || busy !== 1'b0) en_seen = 1;
        end
        check("refresh_after_rst_ignored", en_seen, 0);

        // Fresh start restarts from ROM index 0
        done_before = done_cnt;
        push_frame(1);
        pulse_req(1, 0);
        run_master(0, 0, 0);
        repeat (4) @(negedge CLK);
        check("restart_done_count", done_cnt - done_before, 1);
        check("restart_busy_end", busy, 0);
        check("restart_queue_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
